// File: rtl/meas_capture.sv
// Frame assembler: packs decimated 12-bit samples into a header + payload byte buffer
// and holds the completed frame for the protocol block until it is acknowledged.
module meas_capture #(
    parameter int unsigned N_SAMPLES = 64,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DEC_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        controlstate,
    input  logic              cap_en,
    input  logic [11:0]       sample_in,
    input  logic              sample_valid,
    input  logic [DEC_W-1:0]  decim,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              busy
);

    localparam int unsigned FRAME_BYTES = 2 + (3 * N_SAMPLES) / 2;
    localparam int unsigned CNT_W       = $clog2(N_SAMPLES);
    localparam logic [3:0]  ACTIVE_ST   = 4'h7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_buf [FRAME_BYTES];
    logic [7:0]        r_seq;
    logic              r_overrun;
    logic [DEC_W-1:0]  r_decim;
    logic [DEC_W-1:0]  r_decim_cnt;
    logic [CNT_W-1:0]  r_sample_cnt;
    logic [ADDR_W-1:0] r_wptr;
    logic [3:0]        r_a_lo;
    logic [7:0]        r_rd_data;
    logic              r_frame_ready;
    logic              r_busy;

    logic              w_en;
    logic              w_fill_start;
    logic              w_valid_fill;
    logic              w_take;
    logic              w_last;
    logic              w_wa_en;
    logic [ADDR_W-1:0] w_wa_addr;
    logic [7:0]        w_wa_data;
    logic              w_wb_en;
    logic [ADDR_W-1:0] w_wb_addr;
    logic [7:0]        w_wb_data;

    assign w_en         = cap_en && (controlstate == ACTIVE_ST);
    assign w_fill_start = (r_state == S_IDLE) && w_en;
    assign w_valid_fill = (r_state == S_FILL) && w_en && sample_valid;
    assign w_take       = w_valid_fill && (r_decim_cnt == '0);
    assign w_last       = w_take && (r_sample_cnt == CNT_W'(N_SAMPLES - 1));

    assign rd_data      = r_rd_data;
    assign frame_ready  = r_frame_ready;
    assign busy         = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_en) w_state_nxt = S_FILL;
            S_FILL: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: if (frame_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Two buffer write ports: header pair at fill start, or the two bytes closing a sample pair
    always_comb begin
        w_wa_en   = 1'b0;
        w_wa_addr = '0;
        w_wa_data = '0;
        w_wb_en   = 1'b0;
        w_wb_addr = '0;
        w_wb_data = '0;
        if (w_fill_start) begin
            w_wa_en   = 1'b1;
            w_wa_addr = ADDR_W'(0);
            w_wa_data = r_seq;
            w_wb_en   = 1'b1;
            w_wb_addr = ADDR_W'(1);
            w_wb_data = {r_overrun, 3'b000, controlstate};
        end else if (w_take) begin
            if (!r_sample_cnt[0]) begin
                w_wa_en   = 1'b1;
                w_wa_addr = r_wptr;
                w_wa_data = sample_in[11:4];
            end else begin
                w_wa_en   = 1'b1;
                w_wa_addr = r_wptr + ADDR_W'(1);
                w_wa_data = {r_a_lo, sample_in[11:8]};
                w_wb_en   = 1'b1;
                w_wb_addr = r_wptr + ADDR_W'(2);
                w_wb_data = sample_in[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wa_en) r_buf[w_wa_addr] <= w_wa_data;
        if (w_wb_en) r_buf[w_wb_addr] <= w_wb_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq         <= '0;
            r_overrun     <= 1'b0;
            r_decim       <= '0;
            r_decim_cnt   <= '0;
            r_sample_cnt  <= '0;
            r_wptr        <= ADDR_W'(2);
            r_a_lo        <= '0;
            r_rd_data     <= '0;
            r_frame_ready <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_busy        <= (w_state_nxt == S_FILL);
            r_frame_ready <= (w_state_nxt == S_DONE);
            r_rd_data     <= (rd_addr < ADDR_W'(FRAME_BYTES)) ? r_buf[rd_addr] : 8'h00;

            if (w_fill_start) begin
                r_decim      <= decim;
                r_decim_cnt  <= '0;
                r_sample_cnt <= '0;
                r_wptr       <= ADDR_W'(2);
                r_overrun    <= 1'b0;
            end else if (w_valid_fill) begin
                r_decim_cnt <= (r_decim_cnt == r_decim) ? '0 : r_decim_cnt + DEC_W'(1);
                if (w_take) begin
                    if (!w_last) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    if (!r_sample_cnt[0]) begin
                        r_a_lo <= sample_in[3:0];
                    end else begin
                        r_wptr <= r_wptr + ADDR_W'(3);
                    end
                end
            end

            // Frame is frozen in DONE: late samples only flag overrun for the next header
            if (r_state == S_DONE) begin
                if (sample_valid) r_overrun <= 1'b1;
                if (frame_ack)    r_seq     <= r_seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_meas_capture.sv
// Directed bench for meas_capture: a byte-level scoreboard is filled as samples are
// driven and drained through the read port once the frame is held.
module tb_meas_capture;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEC_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [3:0]        controlstate;
    logic              cap_en;
    logic [11:0]       sample_in;
    logic              sample_valid;
    logic [DEC_W-1:0]  decim;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_ready;
    logic              frame_ack;
    logic              busy;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } sb_t;

    sb_t        sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_seq;
    logic       exp_ovr;
    logic [7:0] seq_before;

    meas_capture #(.N_SAMPLES(64), .ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .controlstate (controlstate),
        .cap_en       (cap_en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .decim        (decim),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .frame_ack    (frame_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a frame from IDLE and drives valids until frame_ready; pushes the expected bytes
    task automatic fill_frame(input int dec, input int mul, input int exp_valids);
        int         idx;
        int         acc;
        logic [11:0] v;
        logic [11:0] a;
        decim        = DEC_W'(dec);
        cap_en       = 1'b1;
        controlstate = 4'h7;
        sb.push_back('{0, exp_seq});
        sb.push_back('{1, {exp_ovr, 3'b000, 4'h7}});
        exp_ovr      = 1'b0;
        sample_in    = 12'hABC;
        sample_valid = 1'b1;
        tick();
        check("busy_in_fill", 32'(busy), 32'd1);
        idx = 0;
        acc = 0;
        a   = '0;
        while (!frame_ready && idx < 64 * (dec + 1) + 8) begin
            v            = 12'(idx * mul);
            sample_in    = v;
            sample_valid = 1'b1;
            if (idx % (dec + 1) == 0) begin
                if (acc % 2 == 0) begin
                    a = v;
                    sb.push_back('{2 + 3 * (acc / 2), v[11:4]});
                end else begin
                    sb.push_back('{3 + 3 * (acc / 2), {a[3:0], v[11:8]}});
                    sb.push_back('{4 + 3 * (acc / 2), v[7:0]});
                end
                acc++;
            end
            tick();
            idx++;
        end
        sample_valid = 1'b0;
        check("valids_to_ready", 32'(idx), 32'(exp_valids));
        check("frame_ready_set", 32'(frame_ready), 32'd1);
        check("busy_after_fill", 32'(busy), 32'd0);
    endtask

    task automatic read_frame(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e       = sb.pop_front();
            rd_addr = ADDR_W'(e.addr);
            tick();
            check($sformatf("%s_byte%0d", tag, e.addr), 32'(rd_data), 32'(e.data));
        end
    endtask

    task automatic read_byte(input string tag, input int addr, input logic [7:0] exp);
        rd_addr = ADDR_W'(addr);
        tick();
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("ready_clear_on_ack", 32'(frame_ready), 32'd0);
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        reset_n      = 1'b0;
        controlstate = 4'h0;
        cap_en       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        decim        = '0;
        rd_addr      = '0;
        frame_ack    = 1'b0;
        exp_seq      = 8'h00;
        exp_ovr      = 1'b0;
        repeat (3) tick();
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_frame_ready", 32'(frame_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Full frame, no decimation
        fill_frame(0, 17, 64);
        read_byte("t1_byte0", 0, 8'h00);
        read_byte("t1_byte1", 1, 8'h07);
        read_byte("t1_byte2", 2, 8'h00);
        read_byte("t1_byte3", 3, 8'h00);
        read_byte("t1_byte4", 4, 8'h11);
        read_frame("t1");
        ack();

        // Decimate by 4, then overrun while held; the buffer must stay frozen
        fill_frame(3, 13, 253);
        repeat (5) begin
            sample_in    = 12'h555;
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        exp_ovr      = 1'b1;
        check("t3_ready_held", 32'(frame_ready), 32'd1);
        read_frame("t2");
        ack();
        fill_frame(0, 29, 64);
        read_byte("t3_byte1_ovr", 1, 8'h87);
        read_frame("t3a");
        ack();
        fill_frame(0, 5, 64);
        read_byte("t3_byte1_clr", 1, 8'h07);
        read_frame("t3b");
        ack();

        // Abort mid-fill; stray ack while idle is ignored
        cap_en       = 1'b1;
        controlstate = 4'h7;
        tick();
        for (int i = 0; i < 30; i++) begin
            sample_in    = 12'(i * 3 + 1);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        controlstate = 4'h4;
        tick();
        check("t4_busy_abort", 32'(busy), 32'd0);
        check("t4_ready_abort", 32'(frame_ready), 32'd0);
        repeat (3) tick();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("t4_ready_stray_ack", 32'(frame_ready), 32'd0);
        seq_before = exp_seq;
        fill_frame(0, 3, 64);
        read_byte("t4_seq_kept", 0, seq_before);
        read_frame("t4");
        ack();

        // Sequence wrap and out-of-range reads
        do begin
            fill_frame(0, 1, 64);
            sb.delete();
            ack();
        end while (exp_seq != 8'h00);
        fill_frame(0, 11, 64);
        read_byte("t5_seq_wrap", 0, 8'h00);
        read_frame("t5");
        read_byte("t5_addr100", 100, 8'h00);
        read_byte("t5_addr127", 127, 8'h00);
        ack();

        // Asynchronous reset mid-fill
        rd_addr      = ADDR_W'(4);
        cap_en       = 1'b1;
        controlstate = 4'h7;
        tick();
        for (int i = 0; i < 10; i++) begin
            sample_in    = 12'(i * 7 + 2);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        #2;
        check("t6_fill_rst_busy", 32'(busy), 32'd0);
        check("t6_fill_rst_ready", 32'(frame_ready), 32'd0);
        check("t6_fill_rst_rd", 32'(rd_data), 32'd0);
        tick();
        cap_en  = 1'b0;
        reset_n = 1'b1;
        exp_seq = 8'h00;
        exp_ovr = 1'b0;
        sb.delete();
        tick();
        fill_frame(0, 9, 64);
        read_frame("t6a");

        // Asynchronous reset while a frame is held
        rd_addr = ADDR_W'(4);
        tick();
        check("t6_pre_rst_rd", 32'(rd_data), 32'h09);
        reset_n = 1'b0;
        #2;
        check("t6_done_rst_busy", 32'(busy), 32'd0);
        check("t6_done_rst_ready", 32'(frame_ready), 32'd0);
        check("t6_done_rst_rd", 32'(rd_data), 32'd0);
        tick();
        cap_en  = 1'b0;
        reset_n = 1'b1;
        exp_seq = 8'h00;
        exp_ovr = 1'b0;
        tick();
        fill_frame(0, 21, 64);
        read_frame("t6b");
        ack();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
